// File: rtl/exe_muldiv_if.sv
// exe_muldiv_if: request/response bundle for the execute-stage M-extension unit.
//   I_valid/I_op/I_srca/I_srcb/I_annul : request from the execute stage
//   O_ready/O_busy                     : combinational status back to the stage
//   O_done/O_result                    : registered completion pulse and result
// The master modport is the execute stage; the slave modport is exe_muldiv.
interface exe_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            I_valid;
    logic            O_ready;
    logic [2:0]      I_op;
    logic [XLEN-1:0] I_srca;
    logic [XLEN-1:0] I_srcb;
    logic            I_annul;
    logic            O_busy;
    logic            O_done;
    logic [XLEN-1:0] O_result;

    modport master (
        output I_valid, I_op, I_srca, I_srcb, I_annul,
        input  O_ready, O_busy, O_done, O_result
    );

    modport slave (
        input  I_valid, I_op, I_srca, I_srcb, I_annul,
        output O_ready, O_busy, O_done, O_result
    );
endinterface

// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle RISC-V M-extension unit (MUL..REMU) for execute.
// Shift-add multiply retiring MUL_BITS multiplier bits per cycle, restoring
// divide at one quotient bit per cycle, one-cycle divide special cases and a
// one-entry result cache so MULH->MUL and DIV->REM pairs finish in one cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : exe_muldiv_if slave (request, annul, ready/busy, done/result)
module exe_muldiv #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 2,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    exe_muldiv_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned MUL_N = XLEN / MUL_BITS;
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned SW    = XLEN + MUL_BITS;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_n;

    // Datapath and cache registers
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    p;        // mul: {acc, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]  opnd;     // mul: multiplicand magnitude; div: divisor magnitude
    logic             res_neg;  // negate product / quotient in FIX
    logic             rem_neg;  // negate remainder in FIX
    logic [2:0]       op_q;
    logic [XLEN-1:0]  srca_q, srcb_q;
    logic             done;
    logic [XLEN-1:0]  result;

    logic             c_valid, c_mul;
    logic [1:0]       c_tag;
    logic [XLEN-1:0]  c_a, c_b, c_lo, c_hi;

    // Request decode
    logic             req_mul, req_sgn_div, req_hi;
    logic [1:0]       req_tag;
    logic             a_neg_c, b_neg_c;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             div_zero, div_ovf, special_c, hit_c, fast_c;
    logic [XLEN-1:0]  spec_res, hit_res;
    logic             ready_c, busy_c, accept_c;

    // Iteration and fixup
    logic [MUL_BITS-1:0] mul_dig;
    logic [SW-1:0]       mul_sum;
    logic [XLEN:0]       div_sh, div_diff;
    logic [PW-1:0]       p_next, prod_fix;
    logic [XLEN-1:0]     fix_lo, fix_hi, fix_res;

    // Signedness tag: mul {sa,sb}; div {0,signed}
    function automatic logic [1:0] tag_of(input logic [2:0] op);
        logic [1:0] t;
        if (op[2]) begin
            t = {1'b0, ~op[0]};
        end else begin
            t = {(op == 3'd1) || (op == 3'd2), op == 3'd1};
        end
        return t;
    endfunction

    // Decode the presented request: magnitudes, special cases, cache hit
    always_comb begin
        req_mul     = ~bus.I_op[2];
        req_tag     = tag_of(bus.I_op);
        req_sgn_div = bus.I_op[2] & ~bus.I_op[0];
        req_hi      = req_mul ? (bus.I_op != 3'd0) : bus.I_op[1];
        a_neg_c     = bus.I_srca[XLEN-1] & (req_mul ? req_tag[1] : req_sgn_div);
        b_neg_c     = bus.I_srcb[XLEN-1] & (req_mul ? req_tag[0] : req_sgn_div);
        a_mag       = a_neg_c ? -bus.I_srca : bus.I_srca;
        b_mag       = b_neg_c ? -bus.I_srcb : bus.I_srcb;
        div_zero    = bus.I_op[2] && (bus.I_srcb == '0);
        div_ovf     = req_sgn_div && (bus.I_srca == MIN_NEG) && (bus.I_srcb == '1);
        special_c   = div_zero || div_ovf;
        if (div_zero) begin
            spec_res = bus.I_op[1] ? bus.I_srca : '1;
        end else begin
            spec_res = bus.I_op[1] ? '0 : bus.I_srca;
        end
        // MUL's low half does not depend on signedness, so it ignores the tag
        hit_c   = CACHE_EN && c_valid && (c_a == bus.I_srca) && (c_b == bus.I_srcb)
                  && (c_mul == req_mul)
                  && ((c_tag == req_tag) || (bus.I_op == 3'd0));
        hit_res = req_hi ? c_hi : c_lo;
        fast_c  = special_c || hit_c;
    end

    // One iteration step for both datapaths
    always_comb begin
        mul_dig  = p[MUL_BITS-1:0];
        mul_sum  = SW'(p[PW-1:XLEN]) + SW'(opnd) * SW'(mul_dig);
        div_sh   = p[PW-1:XLEN-1];
        div_diff = div_sh - {1'b0, opnd};
        if (op_q[2]) begin
            p_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], p[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
        end else begin
            p_next = {mul_sum, p[XLEN-1:MUL_BITS]};
        end
    end

    // Sign correction and result selection
    always_comb begin
        prod_fix = res_neg ? -p : p;
        if (op_q[2]) begin
            fix_lo = res_neg ? -p[XLEN-1:0] : p[XLEN-1:0];
            fix_hi = rem_neg ? -p[PW-1:XLEN] : p[PW-1:XLEN];
        end else begin
            fix_lo = prod_fix[XLEN-1:0];
            fix_hi = prod_fix[PW-1:XLEN];
        end
        fix_res = (op_q[2] ? op_q[1] : (op_q != 3'd0)) ? fix_hi : fix_lo;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_n  = state;
        ready_c  = 1'b0;
        busy_c   = 1'b0;
        accept_c = 1'b0;
        case (state)
            IDLE, DONE: begin
                ready_c = 1'b1;
                if (state == DONE) begin
                    state_n = IDLE;
                end
                if (bus.I_valid && !bus.I_annul) begin
                    accept_c = 1'b1;
                    busy_c   = !fast_c;
                    state_n  = fast_c ? DONE : CALC;
                end
            end
            CALC: begin
                busy_c = 1'b1;
                if (bus.I_annul) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                busy_c  = 1'b1;
                state_n = bus.I_annul ? IDLE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand load, iteration, result and cache update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            p       <= '0;
            opnd    <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            op_q    <= '0;
            srca_q  <= '0;
            srcb_q  <= '0;
            done    <= 1'b0;
            result  <= '0;
            c_valid <= 1'b0;
            c_mul   <= 1'b0;
            c_tag   <= '0;
            c_a     <= '0;
            c_b     <= '0;
            c_lo    <= '0;
            c_hi    <= '0;
        end else begin
            done <= (state_n == DONE);
            if (accept_c) begin
                op_q   <= bus.I_op;
                srca_q <= bus.I_srca;
                srcb_q <= bus.I_srcb;
                if (special_c) begin
                    result <= spec_res;
                end else if (hit_c) begin
                    result <= hit_res;
                end else begin
                    cnt     <= req_mul ? CNT_W'(MUL_N - 1) : CNT_W'(XLEN - 1);
                    opnd    <= req_mul ? a_mag : b_mag;
                    p       <= {{XLEN{1'b0}}, (req_mul ? b_mag : a_mag)};
                    res_neg <= a_neg_c ^ b_neg_c;
                    rem_neg <= a_neg_c;
                end
            end else if ((state == CALC) && !bus.I_annul) begin
                p   <= p_next;
                cnt <= cnt - CNT_W'(1);
            end else if ((state == FIX) && !bus.I_annul) begin
                result <= fix_res;
                if (CACHE_EN) begin
                    c_valid <= 1'b1;
                    c_mul   <= ~op_q[2];
                    c_tag   <= tag_of(op_q);
                    c_a     <= srca_q;
                    c_b     <= srcb_q;
                    c_lo    <= fix_lo;
                    c_hi    <= fix_hi;
                end
            end
        end
    end

    assign bus.O_ready  = ready_c;
    assign bus.O_busy   = busy_c;
    assign bus.O_done   = done;
    assign bus.O_result = result;
endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed scoreboard bench for exe_muldiv (XLEN=32, MUL_BITS=2).
// Stimulus pushes {result, latency} per request; a negedge monitor records
// accept edges and pops/compares on every O_done.
module tb_exe_muldiv;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
                           OP_MULHU = 3'd3, OP_DIV = 3'd4, OP_DIVU = 3'd5,
                           OP_REM = 3'd6, OP_REMU = 3'd7;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   w;
    logic [31:0] last_exp;
    exp_t exp_q[$];
    int   acc_q[$];

    exe_muldiv_if #(.XLEN(32)) bus ();

    exe_muldiv #(.XLEN(32), .MUL_BITS(2), .CACHE_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: completion check first, then note an accept on the coming edge
    always @(negedge clk) begin
        if (!rst) begin
            acc_q.delete();
        end else begin
            if (bus.O_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: result 0x%08h at cycle %0d", bus.O_result, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", bus.O_result, e.res);
                    if (acc_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL latency: done without accept at cycle %0d", cyc);
                    end else begin
                        int a;
                        a = acc_q.pop_front();
                        check("latency", 32'(cyc - a + 1), 32'(e.lat));
                    end
                end
            end
            if (bus.I_annul && !bus.O_ready) acc_q.delete();
            if (bus.I_valid && bus.O_ready && !bus.I_annul) acc_q.push_back(cyc + 1);
        end
    end

    // Issue one request once ready; called and returns at posedge+1
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input bit chk,
                         input bit hold, output int waited);
        waited = 0;
        while (!bus.O_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.O_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: ready 0 after %0d cycles, required 1", waited);
            return;
        end
        bus.I_valid = 1'b1;
        bus.I_op    = op;
        bus.I_srca  = a;
        bus.I_srcb  = b;
        if (chk) begin
            exp_q.push_back('{res: res, lat: lat});
            last_exp = res;
        end
        @(negedge clk);
        check("busy_at_accept", 32'(bus.O_busy), 32'(lat > 1));
        @(posedge clk); #1;
        if (!hold) bus.I_valid = 1'b0;
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; last_exp = '0;
        rst = 1'b0;
        bus.I_valid = 1'b0; bus.I_annul = 1'b0;
        bus.I_op = '0; bus.I_srca = '0; bus.I_srcb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.O_ready), 32'd1);
        check("rst_busy", 32'(bus.O_busy), 32'd0);
        check("rst_done", 32'(bus.O_done), 32'd0);
        check("rst_result", bus.O_result, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Multiply and cache tag behaviour
        issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 18, 1, 0, w);
        issue(OP_MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006, 1,  1, 0, w);
        issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 18, 1, 0, w);
        issue(OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 1,  1, 0, w);
        issue(OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 18, 1, 0, w);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 18, 1, 0, w);
        issue(OP_MUL,    32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1,  1, 0, w);
        issue(OP_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 18, 1, 0, w);

        // Divide and cache pairing
        issue(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1, 0, w);
        issue(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1,  1, 0, w);
        issue(OP_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34, 1, 0, w);
        issue(OP_REMU,   32'hFFFFFFF9, 32'd2,        32'h00000001, 1,  1, 0, w);

        // Special cases
        issue(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  1, 0, w);
        issue(OP_REMU,   32'd5,        32'd0,        32'h00000005, 1,  1, 0, w);
        issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1, 0, w);
        issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1, 0, w);
        issue(OP_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  1, 0, w);

        // Signed divide with negative divisor
        issue(OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, 1, 0, w);
        issue(OP_REM,    32'd100,      32'hFFFFFFF9, 32'h00000002, 1,  1, 0, w);

        // Annul at cycle 10 of a divide
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 34, 0, 0, w);
        repeat (9) @(posedge clk);
        #1;
        bus.I_annul = 1'b1;
        @(posedge clk); #1;
        bus.I_annul = 1'b0;
        check("annul_ready", 32'(bus.O_ready), 32'd1);
        check("annul_busy", 32'(bus.O_busy), 32'd0);
        check("annul_result_kept", bus.O_result, last_exp);
        repeat (40) @(posedge clk);
        #1;
        issue(OP_DIV, 32'd1000, 32'd3, 32'h0000014D, 34, 1, 0, w);

        // Held valid, back-to-back MULs accepted in DONE
        issue(OP_MUL, 32'd3,        32'd5,  32'd15,       18, 1, 1, w);
        issue(OP_MUL, 32'h12345678, 32'h10, 32'h23456780, 18, 1, 0, w);
        check("ready_low_cycles", 32'(w), 32'd17);

        // Two latency-1 requests in a row keep O_done high
        issue(OP_MULHU, 32'h12345678, 32'h10, 32'h00000001, 1, 1, 0, w);
        issue(OP_REMU,  32'd5,        32'd0,  32'h00000005, 1, 1, 0, w);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a divide
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 34, 0, 0, w);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_done", 32'(bus.O_done), 32'd0);
        check("midrst_result", bus.O_result, 32'd0);
        check("midrst_ready", 32'(bus.O_ready), 32'd1);
        check("midrst_busy", 32'(bus.O_busy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // Cache must be empty after reset
        issue(OP_MULHU, 32'h12345678, 32'h10, 32'h00000001, 18, 1, 0, w);
        repeat (25) @(posedge clk);
        #1;
        check("pending_responses", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Parametrised multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the execute stage. Replaces the separate fixed-width mul/div paths inside the ALU. It adds:
- an accept/done handshake;
- a configurable multiplier radix;
- one-cycle special-case handling for divide-by-zero and signed overflow;
- annul support;
- a one-entry result cache, so MULH→MUL and DIV→REM pairs on identical operands complete in one cycle.

The execute stage drives `O_busy` into its stall request.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; must be a multiple of `MUL_BITS`.
- `MUL_BITS`, 2, multiplier bits retired per cycle; legal values 1, 2, 4.
- `CACHE_EN`, 1, enables the one-entry result cache (0: every request iterates).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `I_valid` input 1: request present.
- `O_ready` output 1: unit can accept; high in IDLE and DONE.
- `I_op` input 3: RISC-V funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
- `I_srca` input XLEN: rs1 operand (multiplicand / dividend).
- `I_srcb` input XLEN: rs2 operand (multiplier / divisor).
- `I_annul` input 1: abort the in-flight operation.
- `O_busy` output 1: high in CALC and FIX, and in the accept cycle of a request that will iterate.
- `O_done` output 1: one-cycle pulse; `O_result` is valid.
- `O_result` output XLEN: registered result; holds its value until the next `O_done`.

## Operation
- **Accept:** a request is accepted on a rising edge with `I_valid & O_ready & ~I_annul`. The unit latches `I_op`, `I_srca` and `I_srcb`.
- **States:** IDLE, CALC, FIX, DONE.
- **From IDLE or DONE on accept:**
  - special case or cache hit → DONE;
  - otherwise → CALC, with the counter loaded to N−1.
  - N = XLEN/`MUL_BITS` for mul ops; N = XLEN for div ops.
- **From DONE without accept:** → IDLE.
- **CALC:** one iteration per cycle. At counter 0 → FIX.
- **FIX:** applies the sign correction, registers `O_result`, updates the cache, then → DONE.
- **Multiply:**
  - Operands are sign-extended to XLEN+1 bits according to the op: MULH signed×signed, MULHSU signed×unsigned, MULHU/MUL unsigned×unsigned. The magnitude form is used with sign fixup in FIX.
  - Shift-add over `MUL_BITS` multiplier bits per cycle, accumulating a 2·XLEN product.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
- **Divide:**
  - Restoring, 1 quotient bit per cycle, on operand magnitudes.
  - In FIX: quotient negated if the signs differ (signed ops); remainder takes the dividend's sign.
- **Special cases** (one cycle, no CALC):
  - divisor 0 → quotient all-ones, remainder = dividend.
  - DIV/REM with dividend = 2^(XLEN-1) and divisor = all-ones → quotient = dividend, remainder = 0.
- **Cache** (CACHE_EN=1):
  - Holds one entry: srca, srcb, type (mul/div), signedness tag and both result halves (product hi/lo, or quotient/remainder).
  - A mul entry's tag is {sa,sb}.
  - A div entry's tag is signed/unsigned; signed covers DIV/REM, unsigned covers DIVU/REMU.
  - Hit rules:
    - MUL hits any mul entry with equal operands (low half is signedness-independent).
    - MULH* hit only on a matching tag.
    - A div op hits a div entry with matching operands and tag.
  - Written only in FIX. Special-case results are not cached. Invalid after reset.
- **Annul:**
  - `I_annul` in CALC or FIX → IDLE on the next edge. No `O_done`; cache and `O_result` are unchanged.
  - `I_annul` with `I_valid` blocks the accept.
  - `I_annul` in DONE is ignored.
- **Reset:** while `rst` is low, state = IDLE, counter = 0, `O_done` = 0, `O_result` = 0, cache invalid, all datapath registers 0.
- **Outputs after reset:** `O_ready` = 1, `O_busy` = 0.
- **Reset mid-operation:** discards all work; no `O_done` after release.

## Timing
- **Iterative latency:** accept on edge t0 → `O_done` high in the cycle after edge t0+N+1 (N CALC cycles, 1 FIX, then DONE).
  - XLEN=32, `MUL_BITS`=2: mul `O_done` at t0+18.
  - XLEN=32: div `O_done` at t0+34.
- **Special case or cache hit:** `O_done` high in the cycle after t0 (latency 1).
- **Back-to-back:** a new request can be accepted in the DONE cycle. `O_done` drops the following cycle unless that request also has latency 1, in which case it is high again.
- `O_busy` is combinational from state and from the hit/special decode of the current request. `O_done` and `O_result` are registered.
- No combinational path from `I_srca`/`I_srcb` to `O_result`.

## Test plan
- MUL 7 × 0xFFFFFFFD (XLEN=32, `MUL_BITS`=2) → `O_result`=0xFFFFFFEB, `O_done` exactly 18 cycles after accept; MULHU of the same operands → 0x00000006.
- MULH 0x80000000×0x80000000 → 0x40000000; next MUL with the same operands → 0x00000000, cache hit, `O_done` 1 cycle after accept; MULHU next → iterates, result 0x40000000.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD after 34 cycles; REM with the same operands → 0xFFFFFFFF in 1 cycle (cache hit); DIVU with the same operands → iterates, result 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; each `O_done` 1 cycle after accept, `O_busy` never high.
- Start DIV, assert `I_annul` at cycle 10 → IDLE next edge, no `O_done`, `O_result` keeps its prior value; repeat with `rst` low at cycle 10 → all outputs at reset values, no `O_done` after release.
- `I_valid` held high with two different MUL requests issued back-to-back in DONE → two `O_done` pulses 18 cycles apart, correct results, `O_ready` low during CALC/FIX.
